// File: rtl/char_action_fsm_if.sv
// rtl/char_action_fsm_if.sv - control and status bundle between the player input logic and char_action_fsm
//
// Groups the per-character control inputs and the action-state outputs.
//   master : drives frame_tick/btn_*/got_hit, observes state/button_flag/hit_window/phase_frame
//   slave  : the action FSM itself
interface char_action_fsm_if #(
    parameter int CNT_W = 5
);
    logic             frame_tick;   // one-cycle enable per video frame
    logic             btn_left;     // debounced level
    logic             btn_right;    // debounced level
    logic             btn_attack;   // debounced level
    logic             got_hit;      // one-cycle pulse
    logic [3:0]       state;        // registered action state
    logic             button_flag;  // one-cycle movement strobe
    logic             hit_window;   // attack active phases
    logic [CNT_W-1:0] phase_frame;  // frames elapsed in current timed phase

    modport master (
        output frame_tick, btn_left, btn_right, btn_attack, got_hit,
        input  state, button_flag, hit_window, phase_frame
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_attack, got_hit,
        output state, button_flag, hit_window, phase_frame
    );
endinterface

// File: rtl/char_action_fsm.sv
// rtl/char_action_fsm.sv - per-character action state machine feeding the position handler
//
// Turns debounced buttons and the frame tick into a 4-bit action state plus a
// per-frame movement strobe, sequences attack phases by frame count and handles
// hit-stun.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : char_action_fsm_if.slave
//          in  frame_tick, btn_left, btn_right, btn_attack, got_hit
//          out state (registered), button_flag (registered),
//              hit_window (decoded from state), phase_frame (registered)
module char_action_fsm #(
    parameter int ATK_START_FR  = 5,
    parameter int ATK_ACTIVE_FR = 2,
    parameter int ATK_RECOV_FR  = 16,
    parameter int DIR_START_FR  = 4,
    parameter int DIR_ACTIVE_FR = 3,
    parameter int DIR_RECOV_FR  = 15,
    parameter int STUN_FR       = 12,
    parameter int CNT_W         = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    char_action_fsm_if.slave      bus
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LEFT       = 4'd1,
        S_RIGHT      = 4'd2,
        S_ATK_START  = 4'd3,
        S_ATK_ACTIVE = 4'd4,
        S_ATK_RECOV  = 4'd5,
        S_DIR_START  = 4'd6,
        S_DIR_ACTIVE = 4'd7,
        S_DIR_RECOV  = 4'd8,
        S_STUN       = 4'd9
    } state_t;

    // Last phase_frame value of each timed phase.
    localparam logic [CNT_W-1:0] ATK_START_LAST  = CNT_W'(ATK_START_FR - 1);
    localparam logic [CNT_W-1:0] ATK_ACTIVE_LAST = CNT_W'(ATK_ACTIVE_FR - 1);
    localparam logic [CNT_W-1:0] ATK_RECOV_LAST  = CNT_W'(ATK_RECOV_FR - 1);
    localparam logic [CNT_W-1:0] DIR_START_LAST  = CNT_W'(DIR_START_FR - 1);
    localparam logic [CNT_W-1:0] DIR_ACTIVE_LAST = CNT_W'(DIR_ACTIVE_FR - 1);
    localparam logic [CNT_W-1:0] DIR_RECOV_LAST  = CNT_W'(DIR_RECOV_FR - 1);
    localparam logic [CNT_W-1:0] STUN_LAST       = CNT_W'(STUN_FR - 1);

    // The state register is a plain 4-bit vector so that the illegal codes
    // 10..15 are representable and can be recovered from.
    logic [3:0]       state_q,       state_d;
    logic [CNT_W-1:0] phase_frame_q, phase_frame_d;
    logic             button_flag_q, button_flag_d;
    logic             pending_q,     pending_d;
    logic             atk_q,         atk_d;

    logic             atk_rise;
    logic             free_state;
    logic             timed_state;
    logic [CNT_W-1:0] phase_last;
    logic [3:0]       phase_next;
    logic             one_dir;

    assign atk_rise = bus.btn_attack & ~atk_q;
    assign one_dir  = bus.btn_left ^ bus.btn_right;

    // Phase length and successor for the timed states.
    always_comb begin
        free_state  = 1'b0;
        timed_state = 1'b0;
        phase_last  = '0;
        phase_next  = S_IDLE;
        case (state_q)
            S_IDLE, S_LEFT, S_RIGHT: free_state = 1'b1;
            S_ATK_START: begin
                timed_state = 1'b1;
                phase_last  = ATK_START_LAST;
                phase_next  = S_ATK_ACTIVE;
            end
            S_ATK_ACTIVE: begin
                timed_state = 1'b1;
                phase_last  = ATK_ACTIVE_LAST;
                phase_next  = S_ATK_RECOV;
            end
            S_ATK_RECOV: begin
                timed_state = 1'b1;
                phase_last  = ATK_RECOV_LAST;
                phase_next  = S_IDLE;
            end
            S_DIR_START: begin
                timed_state = 1'b1;
                phase_last  = DIR_START_LAST;
                phase_next  = S_DIR_ACTIVE;
            end
            S_DIR_ACTIVE: begin
                timed_state = 1'b1;
                phase_last  = DIR_ACTIVE_LAST;
                phase_next  = S_DIR_RECOV;
            end
            S_DIR_RECOV: begin
                timed_state = 1'b1;
                phase_last  = DIR_RECOV_LAST;
                phase_next  = S_IDLE;
            end
            S_STUN: begin
                timed_state = 1'b1;
                phase_last  = STUN_LAST;
                phase_next  = S_IDLE;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        phase_frame_d = phase_frame_q;
        pending_d     = pending_q;
        atk_d         = bus.btn_attack;

        // Edges outside the free-moving states are dropped, never buffered.
        if (atk_rise && free_state) begin
            pending_d = 1'b1;
        end

        if (bus.got_hit) begin
            // No frame gating; also restarts an ongoing stun.
            state_d       = S_STUN;
            phase_frame_d = '0;
            pending_d     = 1'b0;
        end else if (free_state) begin
            phase_frame_d = '0;
            if (bus.frame_tick) begin
                if (pending_q) begin
                    state_d   = one_dir ? S_DIR_START : S_ATK_START;
                    pending_d = 1'b0;
                end else if (bus.btn_left && !bus.btn_right) begin
                    state_d = S_LEFT;
                end else if (bus.btn_right && !bus.btn_left) begin
                    state_d = S_RIGHT;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end else if (timed_state) begin
            if (bus.frame_tick) begin
                if (phase_frame_q == phase_last) begin
                    state_d       = phase_next;
                    phase_frame_d = '0;
                end else begin
                    phase_frame_d = phase_frame_q + 1'b1;
                end
            end
        end else begin
            // Illegal encoding: recover unconditionally.
            state_d       = S_IDLE;
            phase_frame_d = '0;
        end

        button_flag_d = bus.frame_tick & ~bus.got_hit &
                        ((state_d == S_LEFT) || (state_d == S_RIGHT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            phase_frame_q <= '0;
            button_flag_q <= 1'b0;
            pending_q     <= 1'b0;
            atk_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_frame_q <= phase_frame_d;
            button_flag_q <= button_flag_d;
            pending_q     <= pending_d;
            atk_q         <= atk_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.phase_frame = phase_frame_q;
    assign bus.button_flag = button_flag_q;
    assign bus.hit_window  = (state_q == S_ATK_ACTIVE) || (state_q == S_DIR_ACTIVE);

endmodule

// File: tb/tb_char_action_fsm.sv
// tb/tb_char_action_fsm.sv - directed self-checking bench for char_action_fsm
module tb_char_action_fsm;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   pulse_cnt;

    char_action_fsm_if #(.CNT_W(5)) bus ();

    char_action_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame tick: an idle cycle, then one cycle with frame_tick high.
    // Returns on the negedge after the tick was consumed; button_flag is
    // sampled on both cycles so every pulse is counted exactly once.
    task automatic tick();
        @(negedge clk);
        if (bus.button_flag === 1'b1) pulse_cnt++;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        if (bus.button_flag === 1'b1) pulse_cnt++;
    endtask

    task automatic press_attack();
        @(negedge clk);
        bus.btn_attack = 1'b1;
        @(negedge clk);
        bus.btn_attack = 1'b0;
    endtask

    task automatic hit_pulse();
        @(negedge clk);
        bus.got_hit = 1'b1;
        @(negedge clk);
        bus.got_hit = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.state !== 4'd0 || bus.phase_frame !== 5'd0 || bus.button_flag !== 1'b0 ||
            bus.hit_window !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d phase=%0d flag=%b hw=%b, want 0/0/0/0",
                     bus.state, bus.phase_frame, bus.button_flag, bus.hit_window);
        end
    endtask

    task automatic test_move();
        pulse_cnt = 0;
        bus.btn_left = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_tests++;
            if (bus.state !== 4'd1 || bus.button_flag !== 1'b1) begin
                n_fail++;
                $display("FAIL move_left_%0d: state=%0d flag=%b, want 1/1", k, bus.state, bus.button_flag);
            end
        end
        @(negedge clk);
        if (bus.button_flag === 1'b1) pulse_cnt++;
        n_tests++;
        if (pulse_cnt != 3) begin
            n_fail++;
            $display("FAIL move_left_pulses: got %0d, want 3", pulse_cnt);
        end
        pulse_cnt = 0;
        bus.btn_right = 1'b1;
        tick();
        tick();
        @(negedge clk);
        if (bus.button_flag === 1'b1) pulse_cnt++;
        n_tests++;
        if (bus.state !== 4'd0 || pulse_cnt != 0) begin
            n_fail++;
            $display("FAIL move_both: state=%0d pulses=%0d, want 0/0", bus.state, pulse_cnt);
        end
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
    endtask

    task automatic test_attack();
        int bad;
        logic [3:0] es;
        logic [4:0] ep;
        bad = 0;
        press_attack();
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k <= 5)       begin es = 4'd3; ep = 5'(k - 1); end
            else if (k <= 7)  begin es = 4'd4; ep = 5'(k - 6); end
            else if (k <= 23) begin es = 4'd5; ep = 5'(k - 8); end
            else              begin es = 4'd0; ep = 5'd0;      end
            n_tests++;
            if (bus.state !== es || bus.phase_frame !== ep || bus.hit_window !== (es == 4'd4)) begin
                n_fail++;
                $display("FAIL attack_tick_%0d: state=%0d phase=%0d hw=%b, want %0d/%0d/%b",
                         k, bus.state, bus.phase_frame, bus.hit_window, es, ep, (es == 4'd4));
            end
        end
    endtask

    task automatic test_dir_attack();
        logic [3:0] es;
        bus.btn_right = 1'b1;
        press_attack();
        for (int k = 1; k <= 23; k++) begin
            tick();
            if (k == 10) press_attack();
            if (k <= 4)       es = 4'd6;
            else if (k <= 7)  es = 4'd7;
            else if (k <= 22) es = 4'd8;
            else              es = 4'd0;
            n_tests++;
            if (bus.state !== es || bus.hit_window !== (es == 4'd7)) begin
                n_fail++;
                $display("FAIL dir_tick_%0d: state=%0d hw=%b, want %0d/%b",
                         k, bus.state, bus.hit_window, es, (es == 4'd7));
            end
        end
        // Edge during recovery must not have been buffered.
        tick();
        n_tests++;
        if (bus.state !== 4'd2 || bus.button_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_no_retrigger: state=%0d flag=%b, want 2/1", bus.state, bus.button_flag);
        end
        bus.btn_right = 1'b0;
        tick();
    endtask

    task automatic test_stun();
        press_attack();
        tick();
        tick();
        tick();
        n_tests++;
        if (bus.state !== 4'd3 || bus.phase_frame !== 5'd2) begin
            n_fail++;
            $display("FAIL stun_setup: state=%0d phase=%0d, want 3/2", bus.state, bus.phase_frame);
        end
        hit_pulse();
        n_tests++;
        if (bus.state !== 4'd9 || bus.phase_frame !== 5'd0) begin
            n_fail++;
            $display("FAIL stun_enter: state=%0d phase=%0d, want 9/0", bus.state, bus.phase_frame);
        end
        for (int k = 0; k < 8; k++) tick();
        hit_pulse();
        n_tests++;
        if (bus.state !== 4'd9 || bus.phase_frame !== 5'd0) begin
            n_fail++;
            $display("FAIL stun_restart: state=%0d phase=%0d, want 9/0", bus.state, bus.phase_frame);
        end
        for (int k = 0; k < 11; k++) tick();
        n_tests++;
        if (bus.state !== 4'd9 || bus.phase_frame !== 5'd11) begin
            n_fail++;
            $display("FAIL stun_tick11: state=%0d phase=%0d, want 9/11", bus.state, bus.phase_frame);
        end
        tick();
        n_tests++;
        if (bus.state !== 4'd0) begin
            n_fail++;
            $display("FAIL stun_exit: state=%0d, want 0", bus.state);
        end
        // Pending attack must be dropped by a hit before it starts.
        press_attack();
        hit_pulse();
        for (int k = 0; k < 13; k++) tick();
        n_tests++;
        if (bus.state !== 4'd0) begin
            n_fail++;
            $display("FAIL stun_pending_clear: state=%0d, want 0", bus.state);
        end
    endtask

    task automatic test_hit_priority();
        bus.btn_left = 1'b1;
        tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        bus.got_hit    = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.got_hit    = 1'b0;
        n_tests++;
        if (bus.state !== 4'd9 || bus.button_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_priority: state=%0d flag=%b, want 9/0", bus.state, bus.button_flag);
        end
        bus.btn_left = 1'b0;
        for (int k = 0; k < 12; k++) tick();
    endtask

    task automatic test_illegal();
        @(negedge clk);
        force dut.state_q = 4'd12;
        #1;
        n_tests++;
        if (bus.state !== 4'd12 || bus.hit_window !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_forced: state=%0d hw=%b, want 12/0", bus.state, bus.hit_window);
        end
        release dut.state_q;
        @(negedge clk);
        n_tests++;
        if (bus.state !== 4'd0 || bus.phase_frame !== 5'd0) begin
            n_fail++;
            $display("FAIL illegal_recover: state=%0d phase=%0d, want 0/0", bus.state, bus.phase_frame);
        end
    endtask

    task automatic test_async_reset();
        press_attack();
        for (int k = 0; k < 6; k++) tick();
        n_tests++;
        if (bus.state !== 4'd4 || bus.hit_window !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: state=%0d hw=%b, want 4/1", bus.state, bus.hit_window);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.state !== 4'd0 || bus.phase_frame !== 5'd0 || bus.button_flag !== 1'b0 ||
            bus.hit_window !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_immediate: state=%0d phase=%0d flag=%b hw=%b, want 0/0/0/0",
                     bus.state, bus.phase_frame, bus.button_flag, bus.hit_window);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_tests++;
        if (bus.state !== 4'd0) begin
            n_fail++;
            $display("FAIL areset_pending_clear: state=%0d, want 0", bus.state);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        pulse_cnt      = 0;
        rst            = 1'b1;
        bus.frame_tick = 1'b0;
        bus.btn_left   = 1'b0;
        bus.btn_right  = 1'b0;
        bus.btn_attack = 1'b0;
        bus.got_hit    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        test_reset();
        test_move();
        test_attack();
        test_dir_attack();
        test_stun();
        test_hit_priority();
        test_illegal();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
